// File: rtl/nor_net_evaluator.sv
// nor_net_evaluator: iterates a genome-configured NOR network one registered step per clock.
// Optional build macro NOR_NET_OSC_DETECT_EN adds early exit on period-2 oscillation.
module nor_net_evaluator #(
    parameter int NUM_GATES   = 6,
    parameter int NUM_INPUTS  = 2,
    parameter int NUM_OUTPUTS = 1,
    parameter int MAX_STEPS   = 16,
    localparam int SEL_W      = $clog2(NUM_GATES + NUM_INPUTS + 1),
    localparam int GENOME_LEN = (2 * NUM_GATES + NUM_OUTPUTS) * SEL_W,
    localparam int STEP_W     = $clog2(MAX_STEPS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_shift,
    input  logic                   cfg_bit,
    input  logic                   clear,
    input  logic                   start,
    input  logic [NUM_INPUTS-1:0]  in,
    output logic                   busy,
    output logic                   done,
    output logic                   stable,
    output logic                   osc,
    output logic [STEP_W-1:0]      steps,
    output logic [NUM_GATES-1:0]   gates,
    output logic [NUM_OUTPUTS-1:0] out
);

    localparam int NUM_SRC = 2 ** SEL_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [GENOME_LEN-1:0]   genome_q, genome_d;
    logic [NUM_GATES-1:0]    w_q, w_d;
    logic [NUM_INPUTS-1:0]   in_q, in_d;
    logic [STEP_W-1:0]       steps_q, steps_d;
    logic                    stable_q, stable_d;
    logic                    osc_q, osc_d;
    logic                    done_q, done_d;

    logic [NUM_SRC-1:0]      src_vec;
    logic [NUM_GATES-1:0]    f_w;
    logic                    advance;
    logic                    clr_gates;
    logic                    osc_hit;

    // Selector space: gates, then latched inputs, then constant-0 padding.
    always_comb begin
        src_vec = '0;
        src_vec[NUM_GATES+NUM_INPUTS-1:0] = {in_q, w_q};
    end

    always_comb begin
        f_w = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            f_w[i] = ~(src_vec[genome_q[(2*i)*SEL_W +: SEL_W]] |
                       src_vec[genome_q[(2*i+1)*SEL_W +: SEL_W]]);
        end
    end

    always_comb begin
        out = '0;
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
            out[j] = src_vec[genome_q[(2*NUM_GATES+j)*SEL_W +: SEL_W]];
        end
    end

`ifdef NOR_NET_OSC_DETECT_EN
    logic [NUM_GATES-1:0] w_prev_q, w_prev_d;

    // w_prev only describes this evaluation once an update has been applied.
    assign osc_hit = (steps_q != '0) && (f_w == w_prev_q);

    always_comb begin
        w_prev_d = w_prev_q;
        if (clr_gates) begin
            w_prev_d = '0;
        end else if (advance) begin
            w_prev_d = w_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_prev_q <= '0;
        end else begin
            w_prev_q <= w_prev_d;
        end
    end
`else
    assign osc_hit = 1'b0;
`endif

    // Handshake: start is taken only in IDLE; busy stays high from that edge until
    // the edge that raises done, and done is a single-cycle pulse with busy low.
    always_comb begin
        state_d   = state_q;
        genome_d  = genome_q;
        w_d       = w_q;
        in_d      = in_q;
        steps_d   = steps_q;
        stable_d  = stable_q;
        osc_d     = osc_q;
        done_d    = 1'b0;
        advance   = 1'b0;
        clr_gates = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_shift) begin
                    genome_d = {genome_q[GENOME_LEN-2:0], cfg_bit};
                end
                if (clear) begin
                    w_d       = '0;
                    clr_gates = 1'b1;
                end else if (start) begin
                    in_d     = in;
                    steps_d  = '0;
                    stable_d = 1'b0;
                    osc_d    = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (f_w == w_q) begin
                    stable_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else if (osc_hit) begin
                    osc_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (steps_q == STEP_W'(MAX_STEPS)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    w_d     = f_w;
                    steps_d = steps_q + STEP_W'(1);
                    advance = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            genome_q <= '1;
            w_q      <= '0;
            in_q     <= '0;
            steps_q  <= '0;
            stable_q <= 1'b0;
            osc_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            genome_q <= genome_d;
            w_q      <= w_d;
            in_q     <= in_d;
            steps_q  <= steps_d;
            stable_q <= stable_d;
            osc_q    <= osc_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = done_q;
    assign stable = stable_q;
    assign osc    = osc_q;
    assign steps  = steps_q;
    assign gates  = w_q;

endmodule

// File: tb/tb_nor_net_evaluator.sv
// Directed bench for nor_net_evaluator (6 gates, 2 inputs, 1 output, 16 steps).
// Oscillation expectations follow NOR_NET_OSC_DETECT_EN when the bench is built with it.
module tb_nor_net_evaluator;

`ifdef NOR_NET_OSC_DETECT_EN
    localparam logic [31:0] EXP_OSC       = 32'd1;
    localparam logic [31:0] EXP_OSC_STEPS = 32'd2;
`else
    localparam logic [31:0] EXP_OSC       = 32'd0;
    localparam logic [31:0] EXP_OSC_STEPS = 32'd16;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_shift = 1'b0;
    logic       cfg_bit = 1'b0;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic [1:0] in = 2'b00;
    logic       busy, done, stable, osc;
    logic [4:0] steps;
    logic [5:0] gates;
    logic [0:0] out;

    int err_cnt = 0;
    int chk_cnt = 0;

    nor_net_evaluator dut (
        .clk(clk), .rst_n(rst_n), .cfg_shift(cfg_shift), .cfg_bit(cfg_bit),
        .clear(clear), .start(start), .in(in), .busy(busy), .done(done),
        .stable(stable), .osc(osc), .steps(steps), .gates(gates), .out(out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; shifts MSB first so g lands in place.
    task automatic load_genome(input logic [51:0] g);
        for (int i = 51; i >= 0; i--) begin
            cfg_shift = 1'b1;
            cfg_bit   = g[i];
            @(negedge clk);
        end
        cfg_shift = 1'b0;
        cfg_bit   = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // lat counts falling edges after the accepting edge up to the one showing done.
    task automatic run_eval(input logic [1:0] x, output int lat);
        in    = x;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    logic [51:0] osc_genome;
    logic [51:0] latch_genome;
    int          lat;

    initial begin
        osc_genome         = '1;
        osc_genome[3:0]    = 4'd0;
        osc_genome[7:4]    = 4'd0;
        osc_genome[51:48]  = 4'd0;

        latch_genome        = '1;
        latch_genome[3:0]   = 4'd6;
        latch_genome[7:4]   = 4'd1;
        latch_genome[11:8]  = 4'd7;
        latch_genome[15:12] = 4'd0;
        latch_genome[51:48] = 4'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_gates", {26'd0, gates}, 32'd0);
        check("rst_steps", {27'd0, steps}, 32'd0);
        check("rst_out", {31'd0, out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted mid-run aborts without a done pulse
        load_genome(osc_genome);
        in    = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midrun_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("midrun_gates", {26'd0, gates}, 32'h3F);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_gates", {26'd0, gates}, 32'd0);
        check("abort_steps", {27'd0, steps}, 32'd0);
        check("abort_out", {31'd0, out}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Default genome: every selector constant 0
        run_eval(2'b00, lat);
        check("def_gates", {26'd0, gates}, 32'h3F);
        check("def_stable", {31'd0, stable}, 32'd1);
        check("def_osc", {31'd0, osc}, 32'd0);
        check("def_steps", {27'd0, steps}, 32'd1);
        check("def_lat", lat, 32'd3);
        @(negedge clk);
        check("def_done_pulse", {31'd0, done}, 32'd0);

        // Self-feedback gate0; start/clear/cfg_shift while busy must be ignored
        pulse_clear();
        check("clr_gates", {26'd0, gates}, 32'd0);
        load_genome(osc_genome);
        in    = 2'b00;
        start = 1'b1;
        @(negedge clk);
        check("osc_busy", {31'd0, busy}, 32'd1);
        cfg_shift = 1'b1;
        cfg_bit   = 1'b0;
        clear     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cfg_shift = 1'b0;
        clear     = 1'b0;
        check("osc_w1", {26'd0, gates}, 32'h3F);
        @(negedge clk);
        check("osc_w2", {26'd0, gates}, 32'h3E);
        check("osc_busy2", {31'd0, busy}, 32'd1);
        lat = 3;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("osc_done_seen", {31'd0, done}, 32'd1);
        check("osc_flag", {31'd0, osc}, EXP_OSC);
        check("osc_stable", {31'd0, stable}, 32'd0);
        check("osc_steps", {27'd0, steps}, EXP_OSC_STEPS);
        check("osc_gates", {26'd0, gates}, 32'h3E);
        check("osc_out", {31'd0, out}, 32'd0);
        check("osc_lat", lat, EXP_OSC_STEPS + 32'd2);

        // Same genome again: it must not have been shifted during the busy run
        @(negedge clk);
        pulse_clear();
        run_eval(2'b00, lat);
        check("osc2_flag", {31'd0, osc}, EXP_OSC);
        check("osc2_steps", {27'd0, steps}, EXP_OSC_STEPS);
        check("osc2_gates", {26'd0, gates}, 32'h3E);
        check("osc2_out", {31'd0, out}, 32'd0);

        // Cross-coupled NOR latch
        @(negedge clk);
        load_genome(latch_genome);
        pulse_clear();
        run_eval(2'b10, lat);
        check("set_out", {31'd0, out}, 32'd1);
        check("set_gates", {26'd0, gates}, 32'h3D);
        check("set_steps", {27'd0, steps}, 32'd1);
        check("set_stable", {31'd0, stable}, 32'd1);
        @(negedge clk);
        run_eval(2'b00, lat);
        check("hold1_out", {31'd0, out}, 32'd1);
        check("hold1_steps", {27'd0, steps}, 32'd0);
        check("hold1_stable", {31'd0, stable}, 32'd1);
        check("hold1_lat", lat, 32'd2);
        @(negedge clk);
        run_eval(2'b01, lat);
        check("rst_latch_out", {31'd0, out}, 32'd0);
        check("rst_latch_gates", {26'd0, gates}, 32'h3E);
        check("rst_latch_steps", {27'd0, steps}, 32'd2);
        check("rst_latch_lat", lat, 32'd4);
        @(negedge clk);
        run_eval(2'b00, lat);
        check("hold0_out", {31'd0, out}, 32'd0);
        check("hold0_steps", {27'd0, steps}, 32'd0);
        check("hold0_stable", {31'd0, stable}, 32'd1);

        // clear in IDLE, then clear together with start
        @(negedge clk);
        pulse_clear();
        check("idle_clear", {26'd0, gates}, 32'd0);
        run_eval(2'b10, lat);
        check("reset_set_gates", {26'd0, gates}, 32'h3D);
        @(negedge clk);
        in    = 2'b01;
        clear = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        check("cs_busy", {31'd0, busy}, 32'd0);
        check("cs_gates", {26'd0, gates}, 32'd0);
        check("cs_steps_hold", {27'd0, steps}, 32'd1);
        check("cs_stable_hold", {31'd0, stable}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("cs_no_done", {31'd0, done}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
